// File: rtl/seir_pkg.sv
// Shared definitions for the SEIR agent: state encoding and its width.
package seir_pkg;

    localparam int SEIR_STATE_W = 2;

    typedef enum logic [SEIR_STATE_W-1:0] {
        ST_S = 2'b00,
        ST_E = 2'b01,
        ST_I = 2'b10,
        ST_R = 2'b11
    } seir_state_t;

endpackage

// File: rtl/seir_agent_stage_timer.sv
// Stage timer: counts steps spent in the current SEIR state and flags when
// the next step would reach the per-state limit.
module stage_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             hold,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             reached
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   cnt_plus1;

    // One extra bit so cnt+1 never wraps before the comparison.
    assign cnt_plus1 = {1'b0, cnt_q} + 1'b1;
    assign reached   = (cnt_plus1 >= {1'b0, limit});
    assign cnt       = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (hold) begin
            cnt_d = cnt_q;
        end else if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_plus1[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seir_agent.sv
// Per-individual SEIR state machine advanced by a one-cycle step strobe.
// Optional statistics counters are built when SEIR_AGENT_STATS_EN is defined.
module seir_agent
    import seir_pkg::*;
#(
    parameter int INCUB_STEPS   = 2,
    parameter int MIN_INF_STEPS = 3,
    parameter int MAX_INF_STEPS = 14,
    parameter int IMMUNE_STEPS  = 0,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             infect_bit,
    input  logic             recover_bit,
    input  logic             exposed,
    input  logic             seed_infect,
    output logic [1:0]       state,
    output logic             infected,
    output logic [CNT_W-1:0] stage_cnt,
    output logic             infect_pulse,
    output logic             recover_pulse,
    output logic [CNT_W-1:0] times_infected,
    output logic [15:0]      inf_step_total
);

    localparam int CNT_MAX = (2 ** CNT_W) - 1;

    if (INCUB_STEPS > CNT_MAX || MIN_INF_STEPS > CNT_MAX ||
        MAX_INF_STEPS > CNT_MAX || IMMUNE_STEPS > CNT_MAX) begin : g_bad_width
        $error("seir_agent: a *_STEPS parameter exceeds the CNT_W range");
    end
    if (MAX_INF_STEPS < 1 || MAX_INF_STEPS < MIN_INF_STEPS) begin : g_bad_max
        $error("seir_agent: MAX_INF_STEPS must be >= 1 and >= MIN_INF_STEPS");
    end

    seir_state_t      state_q, state_d;
    logic             infect_pulse_q, infect_pulse_d;
    logic             recover_pulse_q, recover_pulse_d;
    logic             t_clr, t_inc;
    logic [CNT_W-1:0] t_limit;
    logic [CNT_W-1:0] t_cnt;
    logic             t_reached;
    logic [CNT_W:0]   cnt_plus1;
    logic             min_ok;
    logic             infect_now;

    stage_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (t_clr),
        .inc     (t_inc),
        .hold    (~step),
        .limit   (t_limit),
        .cnt     (t_cnt),
        .reached (t_reached)
    );

    assign cnt_plus1  = {1'b0, t_cnt} + 1'b1;
    assign min_ok     = (cnt_plus1 >= (CNT_W+1)'(MIN_INF_STEPS));
    assign infect_now = seed_infect | (exposed & infect_bit);

    always_comb begin
        state_d         = state_q;
        infect_pulse_d  = 1'b0;
        recover_pulse_d = 1'b0;
        t_clr           = 1'b0;
        t_inc           = 1'b0;
        t_limit         = '0;
        case (state_q)
            ST_S: begin
                if (step && infect_now) begin
                    state_d        = (INCUB_STEPS == 0) ? ST_I : ST_E;
                    t_clr          = 1'b1;
                    infect_pulse_d = 1'b1;
                end
            end
            ST_E: begin
                t_limit = CNT_W'(INCUB_STEPS);
                if (step) begin
                    if (t_reached) begin
                        state_d = ST_I;
                        t_clr   = 1'b1;
                    end else begin
                        t_inc = 1'b1;
                    end
                end
            end
            ST_I: begin
                // recover_bit only counts once the minimum dwell has elapsed
                t_limit = CNT_W'(MAX_INF_STEPS);
                if (step) begin
                    if (t_reached || (min_ok && recover_bit)) begin
                        state_d         = ST_R;
                        t_clr           = 1'b1;
                        recover_pulse_d = 1'b1;
                    end else begin
                        t_inc = 1'b1;
                    end
                end
            end
            ST_R: begin
                t_limit = CNT_W'(IMMUNE_STEPS);
                if (step && (IMMUNE_STEPS != 0)) begin
                    if (t_reached) begin
                        state_d = ST_S;
                        t_clr   = 1'b1;
                    end else begin
                        t_inc = 1'b1;
                    end
                end
            end
            default: state_d = ST_S;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_S;
            infect_pulse_q  <= 1'b0;
            recover_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            infect_pulse_q  <= infect_pulse_d;
            recover_pulse_q <= recover_pulse_d;
        end
    end

    assign state         = state_q;
    assign infected      = (state_q == ST_I);
    assign stage_cnt     = t_cnt;
    assign infect_pulse  = infect_pulse_q;
    assign recover_pulse = recover_pulse_q;

`ifdef SEIR_AGENT_STATS_EN
    logic [CNT_W-1:0] times_q;
    logic [15:0]      total_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            times_q <= '0;
            total_q <= '0;
        end else begin
            if (infect_pulse_d && (times_q != {CNT_W{1'b1}})) begin
                times_q <= times_q + 1'b1;
            end
            if (step && (state_q == ST_I) && (total_q != 16'hFFFF)) begin
                total_q <= total_q + 16'd1;
            end
        end
    end

    assign times_infected = times_q;
    assign inf_step_total = total_q;
`else
    assign times_infected = '0;
    assign inf_step_total = '0;
`endif

endmodule

// File: doc/seir_agent.md
# seir_agent

Per-individual epidemic state machine that consumes the Bernoulli event bits produced by the PRBS threshold generators and advances one individual through Susceptible → Exposed → Infected → Recovered (→ Susceptible) on each simulation step. One instance per modelled individual. The instance is fed by two PRBS instances, one for infection and one for recovery probability. Its `infected` output drives the neighbour-exposure logic of adjacent agents.

## Interface

Parameters:
- `INCUB_STEPS`, default 2: steps spent in Exposed; 0 means S goes directly to I.
- `MIN_INF_STEPS`, default 3: steps in Infected before `recover_bit` is honoured.
- `MAX_INF_STEPS`, default 14: forced recovery after this many Infected steps; must be ≥1 and ≥ `MIN_INF_STEPS`.
- `IMMUNE_STEPS`, default 0: steps in Recovered before returning to Susceptible; 0 means permanent immunity.
- `CNT_W`, default 8: stage-timer width. Every *_STEPS value must be ≤ 2^CNT_W−1; this is an elaboration-time check.

Ports:
- `clk`, input, 1: single system clock, rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `step`, input, 1: simulation-step strobe, one cycle wide; state advances only in cycles where it is 1.
- `infect_bit`, input, 1: Bernoulli infection event from upstream PRBS.
- `recover_bit`, input, 1: Bernoulli recovery event from upstream PRBS.
- `exposed`, input, 1: at least one neighbour is infected this step.
- `seed_infect`, input, 1: forces infection of a Susceptible agent (patient zero).
- `state`, output, 2: current state per package encoding.
- `infected`, output, 1: 1 while `state` is I.
- `stage_cnt`, output, CNT_W: steps elapsed in the current state.
- `infect_pulse`, output, 1: one-cycle pulse on an S→E transition, or S→I when `INCUB_STEPS`=0.
- `recover_pulse`, output, 1: one-cycle pulse on an I→R transition.
- `times_infected`, output, CNT_W: count of infections; only when stats are enabled.
- `inf_step_total`, output, 16: cumulative steps spent in I; only when stats are enabled.

## Operation

- All outputs are registered. Reset values:
  - `state` is S.
  - `stage_cnt`, both pulses and both stats counters are 0.
- Cycles with `step`=0:
  - `state` and `stage_cnt` hold.
  - Pulses are 0.
  - All other inputs are ignored.
- On `step`=1, next state is decided from the current state. Let `c = stage_cnt+1`.
- S:
  - Infection occurs if `seed_infect`, or if both `exposed` and `infect_bit`.
  - On infection: go to E, or to I if `INCUB_STEPS`=0; `stage_cnt`←0; `infect_pulse`←1.
  - If `seed_infect` and `exposed & infect_bit` are both true, this counts as one infection event.
  - With no infection, `stage_cnt` holds at 0.
- E:
  - If `c ≥ INCUB_STEPS`: go to I, `stage_cnt`←0.
  - Otherwise `stage_cnt`←c.
- I:
  - If `c ≥ MAX_INF_STEPS`: go to R.
  - Else if `c ≥ MIN_INF_STEPS` and `recover_bit`=1: go to R.
  - Either transition to R sets `stage_cnt`←0 and `recover_pulse`←1.
  - Otherwise `stage_cnt`←c.
  - `recover_bit` is ignored before `MIN_INF_STEPS`.
- R:
  - If `IMMUNE_STEPS`=0: stay in R forever with `stage_cnt` holding at 0.
  - Else if `c ≥ IMMUNE_STEPS`: go to S, `stage_cnt`←0.
  - Otherwise `stage_cnt`←c.
- `seed_infect` is ignored outside S.
- `infect_bit` and `recover_bit` are sampled only in step cycles.
- Reset asserted at any time, including mid-step, returns to the reset values immediately. No partial transition completes.

## Timing

- Step strobe in cycle n updates `state`, `stage_cnt` and the pulses at the rising edge ending cycle n; they are visible in cycle n+1.
- Latency is 1 cycle. The pulses are high for exactly cycle n+1.
- `infected` is derived from the registered state and has no combinational path from inputs.
- Back-to-back `step` in consecutive cycles is legal. Each strobe advances one step.
- Minimum dwell: I lasts at least `MIN_INF_STEPS` steps (minimum 1) and at most `MAX_INF_STEPS` steps.

## Configuration

- Macro `SEIR_AGENT_STATS_EN`.
- Defined:
  - `times_infected` increments on every `infect_pulse` and saturates at all-ones.
  - `inf_step_total` increments on every step taken while in I and saturates at 16'hFFFF.
  - Both counters reset to 0.
- Undefined:
  - Both outputs are tied to 0.
  - No counter logic is synthesised.

## Structure

- Shared package `seir_pkg`:
  - State typedef `seir_state_t`: S=2'b00, E=2'b01, I=2'b10, R=2'b11.
  - Constant `SEIR_STATE_W`=2.
- One natural sub-module, `stage_timer`. It provides:
  - A CNT_W counter with `clr`, `inc` and `hold` controls.
  - A comparison output `reached = (cnt+1 ≥ limit)`, with `limit` as an input.
- The FSM instantiates `stage_timer` once and muxes `limit` per state.

## Test plan

- Reset release, seed infection:
  - Stimulus: reset released; `seed_infect`=1 with `step`.
  - Response: S→E; `infect_pulse`=1 for one cycle; after 2 more steps state is I.
- Forced recovery:
  - Stimulus: `recover_bit`=0 held throughout.
  - Response: state stays I for exactly 14 steps, then goes to R with `recover_pulse`.
- Early recovery gating:
  - Stimulus: `recover_bit`=1 constant.
  - Response: recovery occurs on the 3rd I step, not before.
- Exposure requires both inputs:
  - `exposed`=1 with `infect_bit`=0 for 50 steps: agent stays S.
  - `exposed`=0 with `infect_bit`=1: agent stays S.
  - Both set to 1: infection on that step.
- Waning immunity:
  - Stimulus: `IMMUNE_STEPS`=4.
  - Response: R lasts 4 steps, then S; `step`=0 gaps between steps do not change the count.
  - Reset asserted while in I returns S and `stage_cnt`=0.
- Stats:
  - Stimulus: `SEIR_AGENT_STATS_EN` defined; 3 full infection cycles with 14 I-steps each.
  - Response: `times_infected`=3 and `inf_step_total`=42.
  - Without the macro, both outputs read 0.
